// File: rtl/mem_req_ctrl_pkg.sv
// Shared pipeline package for the execute-to-memory request controller.
// Holds the data and writeback-control widths and the controller state
// encoding, so the controller and its surroundings agree on them.
package mem_req_ctrl_pkg;

    localparam int DATA_W   = 16;
    localparam int WBINFO_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/mem_req_ctrl_sat_counter.sv
// Saturating event counter used for the memory-stage performance counters.
// Ports:
//   clk   - rising-edge clock
//   inc   - count one event this cycle
//   clear - synchronous clear, wins over inc
//   count - current value, sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Memory request controller between the execute and writeback stages.
// Accepts one instruction at a time from execute, issues loads/stores to
// the memory stage and holds the request until Done_DM, then hands the
// result to writeback. Non-memory instructions pass straight to writeback.
// A halt (after any memory operation it carries) parks the block forever.
// Ports:
//   clk, rst                      - clock, synchronous active-low reset
//   ex_valid/ex_ready             - execute handshake
//   ex_ALU, ex_writeData          - address/result and store data
//   ex_readEn, ex_MemWrt, ex_HaltSig, ex_wbInfo - qualifiers and wb control
//   ALU, writeData, readEn, MemWrt, HaltSig     - registered memory request
//   readData, Done_DM, Stall_DM, CacheHit       - memory stage status
//   wb_valid, wb_readData, wb_ALU, wb_wbInfo, wb_halt - writeback strobes/data
//   err                           - sticky flag for load+store requests
//   stall_cnt, hit_cnt            - saturating performance counters
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic [DATA_W-1:0]   ex_ALU,
    input  logic [DATA_W-1:0]   ex_writeData,
    input  logic                ex_readEn,
    input  logic                ex_MemWrt,
    input  logic                ex_HaltSig,
    input  logic [WBINFO_W-1:0] ex_wbInfo,
    output logic                ex_ready,
    output logic [DATA_W-1:0]   ALU,
    output logic [DATA_W-1:0]   writeData,
    output logic                readEn,
    output logic                MemWrt,
    output logic                HaltSig,
    input  logic [DATA_W-1:0]   readData,
    input  logic                Done_DM,
    input  logic                Stall_DM,
    input  logic                CacheHit,
    output logic                wb_valid,
    output logic [DATA_W-1:0]   wb_readData,
    output logic [DATA_W-1:0]   wb_ALU,
    output logic [WBINFO_W-1:0] wb_wbInfo,
    output logic                wb_halt,
    output logic                err,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    hit_cnt
);

    state_t state, next_state;

    logic                accept;
    logic                is_mem;
    logic                halt_pend;
    logic                halt_done;
    logic [WBINFO_W-1:0] pend_info;
    logic                stall_inc;
    logic                hit_inc;

    // Stall_DM is status only; completion is judged solely by Done_DM.
    logic unused_stall;
    assign unused_stall = Stall_DM;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid & ex_ready;
    assign is_mem   = ex_readEn | ex_MemWrt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mem) begin
                        next_state = BUSY;
                    end else if (ex_HaltSig) begin
                        next_state = HALT;
                    end
                end
            end
            BUSY: begin
                if (Done_DM) begin
                    next_state = halt_pend ? HALT : IDLE;
                end
            end
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    // Request and writeback registers. The strobes default low every cycle
    // so each instruction produces exactly one wb_valid / wb_halt pulse.
    // A load+store request is demoted to a plain store and flagged in err.
    // The halt strobe fires once, on the cycle after HALT is entered, so it
    // always follows the writeback of any memory operation it rode along with.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ALU         <= '0;
            writeData   <= '0;
            readEn      <= 1'b0;
            MemWrt      <= 1'b0;
            HaltSig     <= 1'b0;
            wb_valid    <= 1'b0;
            wb_halt     <= 1'b0;
            wb_readData <= '0;
            wb_ALU      <= '0;
            wb_wbInfo   <= '0;
            err         <= 1'b0;
            halt_pend   <= 1'b0;
            halt_done   <= 1'b0;
            pend_info   <= '0;
        end else begin
            wb_valid <= 1'b0;
            wb_halt  <= 1'b0;
            HaltSig  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mem) begin
                            ALU       <= ex_ALU;
                            writeData <= ex_writeData;
                            readEn    <= ex_readEn & ~ex_MemWrt;
                            MemWrt    <= ex_MemWrt;
                            pend_info <= ex_wbInfo;
                            halt_pend <= ex_HaltSig;
                        end else if (!ex_HaltSig) begin
                            wb_valid    <= 1'b1;
                            wb_readData <= '0;
                            wb_ALU      <= ex_ALU;
                            wb_wbInfo   <= ex_wbInfo;
                        end
                        if (ex_readEn && ex_MemWrt) begin
                            err <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (Done_DM) begin
                        wb_valid    <= 1'b1;
                        wb_readData <= readData;
                        wb_ALU      <= ALU;
                        wb_wbInfo   <= pend_info;
                        readEn      <= 1'b0;
                        MemWrt      <= 1'b0;
                        halt_pend   <= 1'b0;
                    end
                end
                HALT: begin
                    if (!halt_done) begin
                        HaltSig   <= 1'b1;
                        wb_halt   <= 1'b1;
                        halt_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_inc = (state == BUSY) & ~Done_DM;
    assign hit_inc   = (state == BUSY) & Done_DM & CacheHit;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .inc   (stall_inc),
        .clear (~rst),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .inc   (hit_inc),
        .clear (~rst),
        .count (hit_cnt)
    );

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl. A driver issues directed and random
// instructions and pushes the writeback it expects (with the cycle it is due)
// into a queue; a monitor on the falling edge pops and compares every
// wb_valid / wb_halt pulse. Counters, err and request outputs are checked
// against a small behavioural model kept by the driver.
module tb_mem_req_ctrl;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_ALU;
    logic [15:0] ex_writeData;
    logic        ex_readEn;
    logic        ex_MemWrt;
    logic        ex_HaltSig;
    logic [7:0]  ex_wbInfo;
    logic        ex_ready;
    logic [15:0] ALU;
    logic [15:0] writeData;
    logic        readEn;
    logic        MemWrt;
    logic        HaltSig;
    logic [15:0] readData;
    logic        Done_DM;
    logic        Stall_DM;
    logic        CacheHit;
    logic        wb_valid;
    logic [15:0] wb_readData;
    logic [15:0] wb_ALU;
    logic [7:0]  wb_wbInfo;
    logic        wb_halt;
    logic        err;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] hit_cnt;

    mem_req_ctrl #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_ALU       (ex_ALU),
        .ex_writeData (ex_writeData),
        .ex_readEn    (ex_readEn),
        .ex_MemWrt    (ex_MemWrt),
        .ex_HaltSig   (ex_HaltSig),
        .ex_wbInfo    (ex_wbInfo),
        .ex_ready     (ex_ready),
        .ALU          (ALU),
        .writeData    (writeData),
        .readEn       (readEn),
        .MemWrt       (MemWrt),
        .HaltSig      (HaltSig),
        .readData     (readData),
        .Done_DM      (Done_DM),
        .Stall_DM     (Stall_DM),
        .CacheHit     (CacheHit),
        .wb_valid     (wb_valid),
        .wb_readData  (wb_readData),
        .wb_ALU       (wb_ALU),
        .wb_wbInfo    (wb_wbInfo),
        .wb_halt      (wb_halt),
        .err          (err),
        .stall_cnt    (stall_cnt),
        .hit_cnt      (hit_cnt)
    );

    typedef struct {
        int          cyc;
        logic [15:0] rd;
        logic [15:0] alu;
        logic [7:0]  info;
    } exp_t;

    exp_t wbq[$];
    int   hq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int          stall_m;
    int          hit_m;
    logic        err_m;
    logic [15:0] last_alu;
    logic [15:0] last_wd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int satInc(input int v);
        return (v < SAT) ? v + 1 : SAT;
    endfunction

    // Scoreboard monitor: every result pulse must match the oldest pending
    // expectation, both in content and in the cycle it was due.
    always @(negedge clk) begin
        exp_t e;
        int   hc;
        if (wbq.size() > 0 && wbq[0].cyc < cyc) begin
            checkOutput("wb_missed", cyc, wbq[0].cyc);
            void'(wbq.pop_front());
        end
        if (hq.size() > 0 && hq[0] < cyc) begin
            checkOutput("halt_missed", cyc, hq[0]);
            void'(hq.pop_front());
        end
        if (wb_valid === 1'b1) begin
            checkOutput("wb_expected", wbq.size() > 0, 1);
            if (wbq.size() > 0) begin
                e = wbq.pop_front();
                checkOutput("wb_cycle", cyc, e.cyc);
                checkOutput("wb_readData", wb_readData, e.rd);
                checkOutput("wb_ALU", wb_ALU, e.alu);
                checkOutput("wb_wbInfo", wb_wbInfo, e.info);
            end
        end
        if (wb_halt === 1'b1 || HaltSig === 1'b1) begin
            checkOutput("halt_pair", {wb_halt, HaltSig}, 2'b11);
            checkOutput("halt_expected", hq.size() > 0, 1);
            if (hq.size() > 0) begin
                hc = hq.pop_front();
                checkOutput("halt_cycle", cyc, hc);
            end
        end
    end

    task automatic checkResetState();
        checkOutput("rst_ready", ex_ready, 1);
        checkOutput("rst_readEn", readEn, 0);
        checkOutput("rst_MemWrt", MemWrt, 0);
        checkOutput("rst_HaltSig", HaltSig, 0);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_wb_halt", wb_halt, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_ALU", ALU, 0);
        checkOutput("rst_writeData", writeData, 0);
        checkOutput("rst_wb_readData", wb_readData, 0);
        checkOutput("rst_wb_ALU", wb_ALU, 0);
        checkOutput("rst_wb_wbInfo", wb_wbInfo, 0);
        checkOutput("rst_stall_cnt", stall_cnt, 0);
        checkOutput("rst_hit_cnt", hit_cnt, 0);
    endtask

    task automatic applyReset();
        rst      = 1'b0;
        ex_valid = 1'b0;
        Done_DM  = 1'b0;
        tick();
        rst      = 1'b1;
        stall_m  = 0;
        hit_m    = 0;
        err_m    = 1'b0;
        last_alu = '0;
        last_wd  = '0;
        checkResetState();
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_stall_cnt"}, stall_cnt, stall_m);
        checkOutput({tag, "_hit_cnt"}, hit_cnt, hit_m);
        checkOutput({tag, "_err"}, err, err_m);
        checkOutput({tag, "_ALU_hold"}, ALU, last_alu);
        checkOutput({tag, "_wd_hold"}, writeData, last_wd);
    endtask

    // Issue one instruction from IDLE. For memory operations the memory
    // stage answers after 'delay' stalled cycles with rdata/hit.
    task automatic applyStimulus(input logic rd, input logic wr, input logic halt,
                                 input logic [15:0] alu, input logic [15:0] wd,
                                 input logic [7:0] info, input int delay,
                                 input logic [15:0] rdata, input logic hit);
        logic  is_mem;
        exp_t  e;
        is_mem       = rd | wr;
        ex_valid     = 1'b1;
        ex_readEn    = rd;
        ex_MemWrt    = wr;
        ex_HaltSig   = halt;
        ex_ALU       = alu;
        ex_writeData = wd;
        ex_wbInfo    = info;
        checkOutput("accept_ready", ex_ready, 1);
        if (rd && wr) err_m = 1'b1;
        if (!is_mem && !halt) begin
            e = '{cyc + 1, 16'h0000, alu, info};
            wbq.push_back(e);
        end
        if (!is_mem && halt) hq.push_back(cyc + 2);
        tick();
        ex_valid     = 1'b0;
        ex_ALU       = 16'($urandom);
        ex_writeData = 16'($urandom);
        ex_wbInfo    = 8'($urandom);
        if (is_mem) begin
            last_alu = alu;
            last_wd  = wd;
            for (int i = 0; i <= delay; i++) begin
                checkOutput("busy_readEn", readEn, rd & ~wr);
                checkOutput("busy_MemWrt", MemWrt, wr);
                checkOutput("busy_ALU", ALU, alu);
                checkOutput("busy_writeData", writeData, wd);
                checkOutput("busy_ready", ex_ready, 0);
                ex_valid = 1'($urandom);
                if (i == delay) begin
                    Done_DM  = 1'b1;
                    Stall_DM = 1'b0;
                    readData = rdata;
                    CacheHit = hit;
                    e = '{cyc + 1, rdata, alu, info};
                    wbq.push_back(e);
                    if (hit) hit_m = satInc(hit_m);
                    if (halt) hq.push_back(cyc + 2);
                end else begin
                    Done_DM  = 1'b0;
                    Stall_DM = 1'b1;
                    CacheHit = 1'($urandom);
                    readData = 16'($urandom);
                    stall_m  = satInc(stall_m);
                end
                tick();
            end
            Done_DM  = 1'b0;
            Stall_DM = 1'b0;
            ex_valid = 1'b0;
        end
        checkOutput("after_readEn", readEn, 0);
        checkOutput("after_MemWrt", MemWrt, 0);
        checkModel("after");
    endtask

    initial begin
        int k;
        logic rd, wr;
        ex_valid = 0; ex_ALU = 0; ex_writeData = 0; ex_readEn = 0; ex_MemWrt = 0;
        ex_HaltSig = 0; ex_wbInfo = 0; readData = 0; Done_DM = 0; Stall_DM = 0;
        CacheHit = 0; rst = 0;
        $display("[TB] start");
        applyReset();

        // Load hit completing on the first BUSY cycle.
        applyStimulus(1, 0, 0, 16'h0040, 16'h0000, 8'h11, 0, 16'h1234, 1);
        // Store with four stalled cycles.
        applyStimulus(0, 1, 0, 16'h0100, 16'hBEEF, 8'h22, 4, 16'h5555, 0);
        // Non-memory instruction.
        applyStimulus(0, 0, 0, 16'h0007, 16'h0abc, 8'h33, 0, 16'h0000, 0);
        // Load+store: issued as a store, err stays set.
        applyStimulus(1, 1, 0, 16'h0200, 16'h00AA, 8'h44, 1, 16'h9999, 1);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("err_sticky", err, 1);

        // Random mix with idle gaps where a stray Done_DM must be ignored.
        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(0, 9);
            rd = (k <= 3) || (k == 9);
            wr = (k >= 4 && k <= 6) || (k == 9);
            applyStimulus(rd, wr, 0, 16'($urandom), 16'($urandom), 8'($urandom),
                          $urandom_range(0, 5), 16'($urandom), 1'($urandom));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                Done_DM  = 1'($urandom);
                CacheHit = 1'($urandom);
                tick();
            end
            Done_DM = 1'b0;
        end
        checkModel("random_end");

        // Reset during the third BUSY cycle aborts the load silently.
        ex_valid = 1; ex_readEn = 1; ex_MemWrt = 0; ex_HaltSig = 0;
        ex_ALU = 16'h0300; ex_wbInfo = 8'h55;
        tick();
        ex_valid = 0;
        tick();
        tick();
        checkOutput("abort_busy", ex_ready, 0);
        applyReset();
        Done_DM = 1; CacheHit = 1; readData = 16'hDEAD;
        tick();
        Done_DM = 0;
        checkResetState();
        applyStimulus(1, 0, 0, 16'h0044, 16'h0000, 8'h66, 2, 16'h4321, 1);

        // Load with halt: writeback, then one halt pulse, then parked.
        applyStimulus(1, 0, 1, 16'h0080, 16'h0000, 8'h77, 2, 16'h7777, 0);
        for (int i = 0; i < 10; i++) begin
            ex_valid = 1'($urandom);
            Done_DM  = 1'($urandom);
            tick();
            checkOutput("halt_ready", ex_ready, 0);
        end
        ex_valid = 0; Done_DM = 0;
        checkModel("halted");

        // Halt on its own.
        applyReset();
        applyStimulus(0, 0, 1, 16'h0009, 16'h0000, 8'h88, 0, 16'h0000, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("halt2_ready", ex_ready, 0);
        end
        applyReset();
        applyStimulus(1, 0, 0, 16'h0050, 16'h0000, 8'h99, 1, 16'hCAFE, 1);
        tick();
        tick();
        checkOutput("wbq_drained", wbq.size(), 0);
        checkOutput("hq_drained", hq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
